imem_boot_loader: RTL
=====================

# imem_boot_loader

Boot-time program loader that sits between an external instruction source (host link or ROM streamer) and `cpuCore`'s debug instruction-memory write port. It holds the core in reset, accepts a stream of instruction words over a valid/ready handshake, and writes them to consecutive word addresses. After the last write it holds reset for a fixed number of cycles, then releases the core. It replaces hand-driven `dbg_wr_en` / `dbg_addr` / `dbg_instr` / `rst` sequencing at the top level.

## Interface
- `XLEN`, default 64: core data width.
- `INSTRUCTION_LENGTH`, default `XLEN/2`: instruction word width and debug address width.
- `RESET_HOLD`, default 4: number of cycles core reset stays asserted after the last write (≥1).
- `COUNT_W`, default 16: width of the word-count input.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: single-cycle request to begin a load. Honoured in IDLE and RUN only.
- `start_addr` in `INSTRUCTION_LENGTH`: byte base address. Bits [1:0] are forced to 0.
- `word_count` in `COUNT_W`: number of words to load; 0 is legal.
- `abort` in 1: cancels a load in progress.
- `s_valid` in 1: instruction beat valid.
- `s_instr` in `INSTRUCTION_LENGTH`: instruction beat data.
- `s_ready` out 1: loader accepts a beat this cycle.
- `dbg_wr_en` out 1: instruction-memory write strobe to the core.
- `dbg_addr` out `INSTRUCTION_LENGTH`: write byte address.
- `dbg_instr` out `INSTRUCTION_LENGTH`: write data.
- `core_rst` out 1: drives the core's `rst`.
- `busy` out 1: high in LOAD or HOLD.
- `done` out 1: high in RUN.

## Operation
- States: IDLE, LOAD, HOLD, RUN.
- Reset values: state IDLE, `core_rst`=1, `dbg_wr_en`=0, `dbg_addr`=0, `dbg_instr`=0, `s_ready`=0, `busy`=0, `done`=0. Internal address, remaining count and hold counter all reset to 0.
- IDLE: `core_rst`=1.
  - `start` with `word_count`≠0 → LOAD. Latch address = `{start_addr[MSB:2],2'b00}` and remaining = `word_count`.
  - `start` with `word_count`=0 → HOLD.
- LOAD: `s_ready`=1, combinational from state.
  - On `s_valid && s_ready`: register `dbg_addr`←address, `dbg_instr`←`s_instr`, `dbg_wr_en`←1. Then address += 4, wrapping modulo 2^`INSTRUCTION_LENGTH`, and remaining −= 1.
  - When the accepted beat has remaining==1 → HOLD.
  - `dbg_wr_en` is otherwise 0. It is a one-cycle pulse per accepted beat, so back-to-back beats give back-to-back pulses.
- `abort` in LOAD → IDLE next cycle. Priority: `abort` beats a beat presented that cycle, and that beat is not accepted and not written. Already-written words remain. `abort` is ignored outside LOAD.
- HOLD: `core_rst`=1. Hold counter runs 0..`RESET_HOLD`−1, then → RUN.
- RUN: `core_rst`=0, `done`=1.
  - `start` → LOAD (or HOLD when count=0). `core_rst` re-asserts the next cycle, with the same latching as IDLE.
- `start` in LOAD or HOLD is ignored.
- `dbg_addr` and `dbg_instr` keep their last written values between strobes.
- `rst` asserted in any state returns all outputs to reset values on the next edge, including mid-LOAD. No partial write strobe is emitted after that edge.

## Timing
- `start` sampled at edge t → LOAD from cycle t+1; `s_ready` high in cycle t+1.
- Beat accepted at edge k → `dbg_wr_en`=1 in cycle k+1 with that beat's address and data.
- Last beat accepted at edge k:
  - HOLD occupies cycles k+1..k+`RESET_HOLD`.
  - `core_rst` falls and `done` rises in cycle k+`RESET_HOLD`+1.
  - The final `dbg_wr_en` pulse (cycle k+1) always precedes core release by ≥`RESET_HOLD` cycles.
- Zero-count start at edge t → HOLD in t+1..t+`RESET_HOLD`, RUN at t+`RESET_HOLD`+1.
- Throughput: one word per cycle with `s_valid` held high.

## Test plan
- Reset, then `start`, `start_addr`=0, `word_count`=1, beat 0x0020B0B7 → one `dbg_wr_en` pulse with `dbg_addr`=0 and `dbg_instr`=0x0020B0B7. With `RESET_HOLD`=4, `core_rst` falls exactly 4 cycles after the pulse cycle; `done`=1.
- `start_addr`=0x103 (forced to 0x100), count 3, `s_valid` toggling 1,0,1,0,1 → pulses at 0x100, 0x104, 0x108 in order; `s_ready` high throughout LOAD.
- `start_addr`=0xFFFFFFFC, count 2 → writes at 0xFFFFFFFC then 0x00000000.
- Count 4, `abort` asserted alongside the 3rd beat → only 2 pulses; state IDLE; `core_rst` stays 1; `done`=0.
- In RUN, `start` with count 0 → `core_rst`=1 for exactly `RESET_HOLD` cycles, no `dbg_wr_en`, then RUN again.
- `rst` asserted mid-LOAD after 1 of 5 beats → next cycle all outputs at reset values; a subsequent load from IDLE works normally.

Source files
------------

// File: rtl/imem_boot_loader.sv
// Boot-time loader: holds the core in reset and streams instruction words into its
// debug instruction-memory write port. After a fixed hold period it releases the core.
module imem_boot_loader #(
  parameter int XLEN               = 64,
  parameter int INSTRUCTION_LENGTH = XLEN / 2,
  parameter int RESET_HOLD         = 4,
  parameter int COUNT_W            = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [INSTRUCTION_LENGTH-1:0] start_addr,
  input  logic [COUNT_W-1:0]            word_count,
  input  logic                          abort,
  input  logic                          s_valid,
  input  logic [INSTRUCTION_LENGTH-1:0] s_instr,
  output logic                          s_ready,
  output logic                          dbg_wr_en,
  output logic [INSTRUCTION_LENGTH-1:0] dbg_addr,
  output logic [INSTRUCTION_LENGTH-1:0] dbg_instr,
  output logic                          core_rst,
  output logic                          busy,
  output logic                          done
);

  localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2,
    RUN  = 2'd3
  } state_t;

  state_t                          state_q, state_d;
  logic [INSTRUCTION_LENGTH-1:0]   addr_q, addr_d;
  logic [COUNT_W-1:0]              remaining_q, remaining_d;
  logic [HOLD_W-1:0]               hold_q, hold_d;
  logic                            wr_en_q, wr_en_d;
  logic [INSTRUCTION_LENGTH-1:0]   wr_addr_q, wr_addr_d;
  logic [INSTRUCTION_LENGTH-1:0]   wr_instr_q, wr_instr_d;
  logic                            accept;

  // Abort wins over a beat presented in the same cycle, so the beat is dropped.
  assign accept = (state_q == LOAD) && s_valid && !abort;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    hold_d      = hold_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_instr_d  = wr_instr_q;

    case (state_q)
      IDLE, RUN: begin
        if (start) begin
          addr_d      = {start_addr[INSTRUCTION_LENGTH-1:2], 2'b00};
          remaining_d = word_count;
          hold_d      = '0;
          state_d     = (word_count == '0) ? HOLD : LOAD;
        end
      end
      LOAD: begin
        if (abort) begin
          state_d = IDLE;
        end else if (accept) begin
          wr_en_d     = 1'b1;
          wr_addr_d   = addr_q;
          wr_instr_d  = s_instr;
          addr_d      = addr_q + INSTRUCTION_LENGTH'(4);
          remaining_d = remaining_q - COUNT_W'(1);
          if (remaining_q == COUNT_W'(1)) begin
            hold_d  = '0;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (hold_q == HOLD_LAST) begin
          hold_d  = '0;
          state_d = RUN;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      hold_q      <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_instr_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      hold_q      <= hold_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_instr_q  <= wr_instr_d;
    end
  end

  assign s_ready   = (state_q == LOAD);
  assign dbg_wr_en = wr_en_q;
  assign dbg_addr  = wr_addr_q;
  assign dbg_instr = wr_instr_q;
  assign core_rst  = (state_q != RUN);
  assign busy      = (state_q == LOAD) || (state_q == HOLD);
  assign done      = (state_q == RUN);

endmodule
